// File: rtl/joystick_pkg.sv
// Shared definitions for the joystick event controller: register addresses,
// read-word field positions and the event record stored in the FIFO.
package joystick_pkg;

  localparam logic [1:0] ADDR_STATE = 2'd0;
  localparam logic [1:0] ADDR_EDGE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_EVENT = 2'd3;

  // Event read word layout (addr 3)
  localparam int RD_VALID_BIT = 31;
  localparam int RD_OVF_BIT   = 30;
  localparam int RD_CNT_LSB   = 16;
  localparam int RD_CNT_W     = 5;
  localparam int EVT_W        = 4;
  localparam int EVT_DIR_BIT  = 3;
  localparam int EVT_IDX_LSB  = 0;

  // Control bits
  localparam int MASK_FIFO_EN_BIT = 8;
  localparam int FLUSH_BIT        = 0;

  // One FIFO entry: dir = 1 for press, idx = line number
  typedef struct packed {
    logic       dir;
    logic [2:0] idx;
  } evt_t;

  // Index of the lowest set bit (0 when none are set)
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/joystick_debounce.sv
// One joystick line: polarity fix, 2-FF synchroniser, stability counter and
// debounced level. change_o pulses for one cycle in the cycle whose clock
// edge updates stable_o, so the parent can latch events on the same edge.
module joystick_debounce
  import joystick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o,
  output logic change_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level;
  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Internal level is always 1 = pressed
  assign level = raw_i ^ ACTIVE_LOW;

  // Bring the asynchronous line into the clk domain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= level;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive differing cycles; accept the new level on the last one
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    change_o = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        change_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/joystick_event_ctrl.sv
// Avalon-MM joystick controller: eight debounced lines, press edge capture
// with write-1-to-clear, interrupt mask, and an event FIFO fed by a
// lowest-index-first scheduler. readdata and irq are registered.
// Bus handshake: a write happens on every clock with chipselect && !write_n;
// a read strobe (chipselect && !read_n) only matters at addr 3, where it pops
// the head entry; readdata tracks the address mux every cycle, one cycle late.
module joystick_event_ctrl
  import joystick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int FIFO_DEPTH      = 8,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [7:0]  in_port,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  logic [7:0] stable, change;

  for (genvar g = 0; g < 8; g++) begin : g_line
    joystick_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW != 0)
    ) u_debounce (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .raw_i    (in_port[g]),
      .stable_o (stable[g]),
      .change_o (change[g])
    );
  end

  logic            wr_en, rd_en;
  logic [7:0]      edge_cap_q, edge_cap_d, edge_clr;
  logic [7:0]      irq_mask_q, irq_mask_d;
  logic            fifo_irq_en_q, fifo_irq_en_d;
  logic [7:0]      pending_q, pending_d;
  logic            overflow_q, overflow_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  evt_t            mem_q [FIFO_DEPTH];
  logic            fifo_empty, fifo_full;
  logic            push_req, push, pop, flush;
  logic [2:0]      grant_idx;
  logic [7:0]      grant_mask;
  evt_t            push_evt, head;
  logic [31:0]     rd_mux;
  logic            irq_d;
  logic            unused_wdata;

  assign unused_wdata = ^writedata[31:9];

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNTW'(FIFO_DEPTH));

  // Scheduler: grant the lowest pending line; event carries its current level
  assign grant_idx  = lowest_set(pending_q);
  assign grant_mask = pending_q & (~pending_q + 8'd1);
  assign push_req   = |pending_q;
  assign flush      = wr_en && (address == ADDR_EVENT) && writedata[FLUSH_BIT];
  assign pop        = rd_en && (address == ADDR_EVENT) && !fifo_empty;
  assign push       = push_req && (!fifo_full || pop);
  assign head       = mem_q[rd_ptr_q];

  // Event record and pending/edge/mask next state
  always_comb begin
    push_evt.dir = stable[grant_idx];
    push_evt.idx = grant_idx;
    // A granted line clears; a fresh change on the same edge re-arms it
    pending_d = (pending_q & ~grant_mask) | change;
    edge_clr  = (wr_en && (address == ADDR_EDGE)) ? writedata[7:0] : 8'h00;
    // Press detection wins over a simultaneous clear
    edge_cap_d    = (edge_cap_q & ~edge_clr) | (change & ~stable);
    irq_mask_d    = irq_mask_q;
    fifo_irq_en_d = fifo_irq_en_q;
    if (wr_en && (address == ADDR_MASK)) begin
      irq_mask_d    = writedata[7:0];
      fifo_irq_en_d = writedata[MASK_FIFO_EN_BIT];
    end
  end

  // FIFO pointer, count and overflow next state; flush overrides everything
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNTW'(1);
        2'b01:   cnt_d = cnt_q - CNTW'(1);
        default: cnt_d = cnt_q;
      endcase
      if (push_req && !push) overflow_d = 1'b1;
    end
  end

  // Read mux; event fields are only shown while the FIFO holds an entry
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATE: rd_mux[7:0] = stable;
      ADDR_EDGE:  rd_mux[7:0] = edge_cap_q;
      ADDR_MASK:  rd_mux[8:0] = {fifo_irq_en_q, irq_mask_q};
      default: begin
        rd_mux[RD_VALID_BIT]              = !fifo_empty;
        rd_mux[RD_OVF_BIT]                = overflow_q;
        rd_mux[RD_CNT_LSB +: RD_CNT_W]    = RD_CNT_W'(cnt_q);
        if (!fifo_empty) rd_mux[EVT_W-1:0] = head;
      end
    endcase
  end

  assign irq_d = (|(edge_cap_q & irq_mask_q)) | (fifo_irq_en_q & ~fifo_empty);

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_evt;
  end

  // Control and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap_q    <= '0;
      irq_mask_q    <= '0;
      fifo_irq_en_q <= 1'b0;
      pending_q     <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      readdata      <= '0;
      irq           <= 1'b0;
    end else begin
      edge_cap_q    <= edge_cap_d;
      irq_mask_q    <= irq_mask_d;
      fifo_irq_en_q <= fifo_irq_en_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      readdata      <= rd_mux;
      irq           <= irq_d;
    end
  end

endmodule

// File: tb/tb_joystick_event_ctrl.sv
// Directed bench for joystick_event_ctrl with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_joystick_event_ctrl;
  import joystick_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;
  logic [3:0]  exp_q[$];

  joystick_event_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each bus task starts and ends on a falling edge and spans one rising edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1;
    d = readdata;
  endtask

  task automatic bus_peek(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b0;
    @(negedge clk);
    d = readdata;
  endtask

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = '0; in_port = 8'hFF;
    idle(3);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    idle(4);

    // 3-cycle glitch on line 2 is rejected
    in_port[2] = 1'b0; idle(3); in_port[2] = 1'b1; idle(12);
    bus_read(ADDR_STATE, rd); check("glitch_state", rd, 32'h0);
    bus_peek(ADDR_EVENT, rd); check("glitch_fifo", rd, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);

    // Hold line 2: stable updates on the 6th rising edge
    in_port[2] = 1'b0; idle(5);
    bus_read(ADDR_STATE, rd); check("lat_before", rd, 32'h0);
    bus_read(ADDR_STATE, rd); check("lat_stable", rd, 32'h4);
    bus_write(ADDR_STATE, 32'hFF);
    bus_read(ADDR_STATE, rd); check("state_ro", rd, 32'h4);
    bus_read(ADDR_EDGE, rd);  check("edge_set", rd, 32'h4);
    bus_write(ADDR_MASK, 32'h4);
    check("irq_lag", 32'(irq), 32'h0);
    idle(1); check("irq_mask", 32'(irq), 32'h1);
    bus_write(ADDR_EDGE, 32'h4);
    check("irq_hold", 32'(irq), 32'h1);
    idle(1); check("irq_clear", 32'(irq), 32'h0);
    bus_read(ADDR_EVENT, rd); check("press2_evt", rd, 32'h8001_000A);
    bus_read(ADDR_EVENT, rd); check("empty_read", rd, 32'h0);
    in_port[2] = 1'b1; idle(12);
    bus_read(ADDR_EVENT, rd); check("release2_evt", rd, 32'h8001_0002);
    bus_read(ADDR_EDGE, rd);  check("edge_no_release", rd, 32'h0);

    // Lines 0 and 5 together: pushed on consecutive edges, lowest first
    in_port = 8'hDE; idle(6);
    bus_peek(ADDR_EVENT, rd); check("evt_pre", rd, 32'h0);
    bus_peek(ADDR_EVENT, rd); check("evt_first", rd, 32'h8001_0008);
    bus_peek(ADDR_EVENT, rd); check("evt_second", rd, 32'h8002_0008);
    bus_read(ADDR_EVENT, rd); check("pop_idx0", rd, 32'h8002_0008);
    bus_read(ADDR_EVENT, rd); check("pop_idx5", rd, 32'h8001_000D);
    bus_read(ADDR_EVENT, rd); check("pop_empty", rd, 32'h0);

    // Six changes into a 4-deep FIFO: overflow, then flush
    in_port = 8'hA5; idle(16);
    bus_peek(ADDR_EVENT, rd); check("ovf_full", rd, 32'hC004_0000);
    bus_read(ADDR_STATE, rd); check("ovf_state", rd, 32'h5A);
    bus_write(ADDR_EVENT, 32'h1);
    bus_peek(ADDR_EVENT, rd); check("flush", rd, 32'h0);

    // Fill with four releases, then pop in the same cycle as a new press
    in_port = 8'hFF; idle(16);
    bus_peek(ADDR_EVENT, rd); check("fill4", rd, 32'h8004_0001);
    in_port = 8'h7F; idle(6);
    bus_read(ADDR_EVENT, rd); check("pop_push_head", rd, 32'h8004_0001);
    bus_peek(ADDR_EVENT, rd); check("pop_push_cnt", rd, 32'h8004_0003);
    exp_q.push_back(4'h3); exp_q.push_back(4'h4);
    exp_q.push_back(4'h6); exp_q.push_back(4'hF);
    for (int i = 4; i >= 1; i--) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      bus_read(ADDR_EVENT, rd);
      check("drain", rd, 32'h8000_0000 | (32'(i) << 16) | 32'(e));
    end
    bus_read(ADDR_EVENT, rd); check("drain_empty", rd, 32'h0);
    bus_peek(ADDR_EVENT, rd); check("no_underflow", rd, 32'h0);

    // FIFO-driven interrupt with edge mask off
    bus_write(ADDR_EDGE, 32'hFF);
    bus_write(ADDR_MASK, 32'h100);
    idle(1); check("fifo_irq_idle", 32'(irq), 32'h0);
    in_port = 8'h77; idle(10);
    check("fifo_irq_set", 32'(irq), 32'h1);
    bus_read(ADDR_MASK, rd);  check("mask_rb", rd, 32'h100);
    bus_read(ADDR_EVENT, rd); check("fifo_irq_evt", rd, 32'h8001_000B);
    check("fifo_irq_lag", 32'(irq), 32'h1);
    idle(1); check("fifo_irq_drained", 32'(irq), 32'h0);

    // Reset in the middle of a debounce with irq asserted
    bus_write(ADDR_MASK, 32'h1FF);
    idle(1); check("pre_reset_irq", 32'(irq), 32'h1);
    in_port = 8'hFF; idle(3);
    reset_n = 1'b0; #1;
    check("async_irq", 32'(irq), 32'h0);
    check("async_rd", readdata, 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(12);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd); check("post_reset_reg", rd, 32'h0);
    end
    check("post_reset_irq", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
